// File: rtl/booth_arith_pkg.sv
// booth_arith_pkg: shared types, widths and signed limits for the Booth multiplier/divider library
package booth_arith_pkg;
  localparam int N_DEF = 8;
  localparam int S_MIN = -(2 ** (N_DEF - 1));
  localparam int S_MAX = 2 ** (N_DEF - 1) - 1;
  typedef enum logic [1:0] {IDLE, ABS, ITER, FIX} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/booth_div_8bit_div_step.sv
// div_step: one combinational restoring-division step on magnitudes
module div_step
  import booth_arith_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N:0]   i_r,
  input  logic         i_bit,
  input  logic [N-1:0] i_dvs,
  output logic [N:0]   o_r,
  output logic         o_q
);
  logic [N+1:0] w_sh;
  assign w_sh = {i_r, i_bit};
  assign o_q  = w_sh >= {2'b0, i_dvs};
  assign o_r  = (N+1)'(o_q ? w_sh - {2'b0, i_dvs} : w_sh);
endmodule

// File: rtl/booth_div_8bit.sv
// booth_div_8bit: sequential signed restoring divider, 2N/N -> N quotient and remainder, truncating toward zero
module booth_div_8bit
  import booth_arith_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           in_clk,
  input  logic           in_rst_n,
  input  logic           in_start,
  input  logic [2*N-1:0] in_dividend,
  input  logic [N-1:0]   in_divisor,
  output logic           o_busy,
  output logic           o_done,
  output logic [N-1:0]   o_quot,
  output logic [N-1:0]   o_rem,
  output logic           o_ovf,
  output logic           o_div0
);
  localparam int W  = 2 * N;
  localparam int CW = clog2(W);
  localparam logic [W-1:0] Q_POS = W'(2 ** (N - 1) - 1);
  localparam logic [W-1:0] Q_NEG = W'(2 ** (N - 1));
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  state_t r_state, w_next;
  logic [W-1:0]  r_dvd, r_mag, r_q, w_qs;
  logic [N-1:0]  r_dvs, r_dva, w_rs;
  logic [N:0]    r_r, w_r;
  logic [CW-1:0] r_cnt;
  logic          r_z, w_qb, w_sd, w_sv, w_neg, w_ovf;

  div_step #(.N(N)) u_step (
    .i_r  (r_r),
    .i_bit(r_mag[W-1]),
    .i_dvs(r_dva),
    .o_r  (w_r),
    .o_q  (w_qb)
  );

  assign w_sd   = r_dvd[W-1];
  assign w_sv   = r_dvs[N-1];
  assign w_neg  = w_sd ^ w_sv;
  assign w_qs   = w_neg ? -r_q : r_q;
  assign w_rs   = N'(w_sd ? -r_r : r_r);
  assign w_ovf  = r_q > (w_neg ? Q_NEG : Q_POS);
  assign o_busy = r_state != IDLE;

  // state register
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) r_state <= IDLE;
    else r_state <= w_next;

  // next-state: accept, take magnitudes, iterate 2N steps, fix up signs
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_start ? ABS : IDLE;
      ABS:     w_next = (r_dvs == '0) ? FIX : ITER;
      ITER:    w_next = (r_cnt == LAST) ? FIX : ITER;
      default: w_next = IDLE;
    endcase
  end

  // datapath: operand capture, restoring iterations and result loading
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_dva  <= '0;
      r_mag  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_cnt  <= '0;
      r_z    <= 1'b0;
      o_done <= 1'b0;
      o_quot <= '0;
      o_rem  <= '0;
      o_ovf  <= 1'b0;
      o_div0 <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE: if (in_start) begin
          r_dvd <= in_dividend;
          r_dvs <= in_divisor;
        end
        ABS: begin
          r_mag <= w_sd ? -r_dvd : r_dvd;
          r_dva <= w_sv ? -r_dvs : r_dvs;
          r_z   <= r_dvs == '0;
          r_q   <= '0;
          r_r   <= '0;
          r_cnt <= '0;
        end
        ITER: begin
          r_r   <= w_r;
          r_q   <= {r_q[W-2:0], w_qb};
          r_mag <= r_mag << 1;
          r_cnt <= r_cnt + 1'b1;
        end
        default: begin
          o_done <= 1'b1;
          o_quot <= r_z ? '0 : w_qs[N-1:0];
          o_rem  <= r_z ? r_dvd[N-1:0] : w_rs;
          o_ovf  <= r_z ? 1'b0 : w_ovf;
          o_div0 <= r_z;
        end
      endcase
    end
endmodule

// File: tb/tb_booth_div_8bit.sv
// tb_booth_div_8bit: randomized and directed checks of the signed divider against an integer-arithmetic model
module tb_booth_div_8bit;
  import booth_arith_pkg::*;
  logic        in_clk = 1'b0, in_rst_n = 1'b0, in_start = 1'b0;
  logic [15:0] in_dividend = '0;
  logic [7:0]  in_divisor = '0;
  logic        o_busy, o_done, o_ovf, o_div0;
  logic [7:0]  o_quot, o_rem;
  int n_chk = 0, n_err = 0;

  booth_div_8bit dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_start(in_start),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .o_busy(o_busy), .o_done(o_done), .o_quot(o_quot), .o_rem(o_rem),
    .o_ovf(o_ovf), .o_div0(o_div0)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [15:0] dd, input logic [7:0] dv,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic ovf, output logic z);
    int a, b, qt, rt;
    a = $signed(dd);
    b = $signed(dv);
    if (b == 0) begin
      q = 8'h00; r = dd[7:0]; ovf = 1'b0; z = 1'b1;
    end else begin
      qt = a / b;
      rt = a % b;
      q = qt[7:0]; r = rt[7:0]; ovf = (qt > S_MAX) || (qt < S_MIN); z = 1'b0;
    end
  endfunction

  task automatic start_op(input logic [15:0] dd, input logic [7:0] dv);
    @(negedge in_clk);
    in_start = 1'b1; in_dividend = dd; in_divisor = dv;
    @(negedge in_clk);
    in_start = 1'b0; in_dividend = 16'($urandom); in_divisor = 8'($urandom);
  endtask

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!o_done && lat < 40) begin
      @(negedge in_clk);
      lat++;
    end
  endtask

  task automatic check_res(input logic [15:0] dd, input logic [7:0] dv, input int lat);
    logic [7:0] q, r;
    logic ovf, z;
    model(dd, dv, q, r, ovf, z);
    chk("latency", lat, z ? 2 : 18);
    chk("quot", o_quot, q);
    chk("rem", o_rem, r);
    chk("ovf", o_ovf, ovf);
    chk("div0", o_div0, z);
    chk("busy_at_done", o_busy, 0);
  endtask

  task automatic run(input logic [15:0] dd, input logic [7:0] dv);
    int lat;
    logic [7:0] q, r;
    logic ovf, z;
    start_op(dd, dv);
    wait_done(0, lat);
    check_res(dd, dv, lat);
    model(dd, dv, q, r, ovf, z);
    @(negedge in_clk);
    chk("done_pulse", o_done, 0);
    chk("quot_hold", o_quot, q);
  endtask

  initial begin
    int lat, seen;
    logic [15:0] dd;
    logic [7:0] dv;
    #12;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_outs", {o_quot, o_rem, o_ovf, o_div0}, 0);
    in_rst_n = 1'b1;
    run(16'd100, 8'd7);
    run(-16'sd100, 8'd7);
    run(16'd100, -8'sd7);
    run(-16'sd100, -8'sd7);
    run(-16'sd16384, 8'h80);
    run(16'sd16384, 8'h80);
    run(16'h8000, 8'h80);
    run(16'h8000, 8'hFF);
    run(16'd1000, 8'd0);
    chk("div0_busy_after", o_busy, 0);
    // start while busy is ignored
    start_op(16'd500, 8'd9);
    repeat (3) @(negedge in_clk);
    in_start = 1'b1; in_dividend = 16'd77; in_divisor = 8'd0;
    @(negedge in_clk);
    in_start = 1'b0;
    wait_done(4, lat);
    check_res(16'd500, 8'd9, lat);
    // back-to-back: start during done cycle
    start_op(16'd1234, 8'd11);
    wait_done(0, lat);
    check_res(16'd1234, 8'd11, lat);
    in_start = 1'b1; in_dividend = -16'sd3000; in_divisor = 8'd25;
    @(negedge in_clk);
    in_start = 1'b0; in_dividend = 16'($urandom); in_divisor = 8'($urandom);
    wait_done(0, lat);
    check_res(-16'sd3000, 8'd25, lat);
    // async reset during iteration 7
    start_op(16'd999, 8'd5);
    repeat (8) @(negedge in_clk);
    #2 in_rst_n = 1'b0;
    #1;
    chk("arst_outs", {o_quot, o_rem, o_ovf, o_div0, o_done, o_busy}, 0);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge in_clk);
      if (o_done) seen++;
    end
    chk("no_done_after_rst", seen, 0);
    run(16'd999, 8'd5);
    // randomized operands, biased towards representable quotients
    for (int i = 0; i < 60; i++) begin
      dv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 1) == 1) dd = 16'($urandom);
      else dd = 16'((int'($urandom_range(0, 255)) - 128) * int'($signed(dv)) +
                    (int'($urandom_range(0, 15)) - 8));
      run(dd, dv);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
